// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA raster timing: pixel counters, visible flag, active-low syncs, frame strobe.
// Define VGA_SYNC_DELAY_EN to delay hs/vs by one extra register stage.
module vga_timing_gen #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       frame_start
);

  localparam int unsigned CNT_W   = 10;
  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS      = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] V_VIS      = CNT_W'(V_VISIBLE);
  localparam logic [CNT_W-1:0] H_SYNC_BEG = CNT_W'(H_VISIBLE + H_FRONT);
  localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [CNT_W-1:0] V_SYNC_BEG = CNT_W'(V_VISIBLE + V_FRONT);
  localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [CNT_W-1:0] hc_q, hc_d;
  logic [CNT_W-1:0] vc_q, vc_d;
  logic             blank_q, blank_d;
  logic             hs_q, hs_d;
  logic             vs_q, vs_d;
  logic             frame_start_q, frame_start_d;

  // Flags decode the next counter values so they land in the same cycle as the counters.
  always_comb begin
    hc_d          = hc_q + CNT_W'(1);
    vc_d          = vc_q;
    frame_start_d = 1'b0;
    if (hc_q == H_LAST) begin
      hc_d = '0;
      if (vc_q == V_LAST) begin
        vc_d          = '0;
        frame_start_d = 1'b1;
      end else begin
        vc_d = vc_q + CNT_W'(1);
      end
    end
    blank_d = (hc_d < H_VIS) && (vc_d < V_VIS);
    hs_d    = !((hc_d >= H_SYNC_BEG) && (hc_d < H_SYNC_END));
    vs_d    = !((vc_d >= V_SYNC_BEG) && (vc_d < V_SYNC_END));
  end

  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      hc_q          <= '0;
      vc_q          <= '0;
      blank_q       <= 1'b1;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      hc_q          <= hc_d;
      vc_q          <= vc_d;
      blank_q       <= blank_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      frame_start_q <= frame_start_d;
    end
  end

`ifdef VGA_SYNC_DELAY_EN
  // Extra stage lines syncs up with RGB registered one cycle after coordinate sampling.
  logic hs_dly_q, hs_dly_d;
  logic vs_dly_q, vs_dly_d;

  always_comb begin
    hs_dly_d = hs_q;
    vs_dly_d = vs_q;
  end

  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      hs_dly_q <= 1'b1;
      vs_dly_q <= 1'b1;
    end else begin
      hs_dly_q <= hs_dly_d;
      vs_dly_q <= vs_dly_d;
    end
  end

  assign hs = hs_dly_q;
  assign vs = vs_dly_q;
`else
  assign hs = hs_q;
  assign vs = vs_q;
`endif

  assign DrawX       = hc_q;
  assign DrawY       = vc_q;
  assign blank       = blank_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default-timing instance plus a shrunken-timing instance so whole
// frames fit in a short run; both are compared every cycle against an arithmetic raster model.
module tb_vga_timing_gen;

  typedef struct packed {
    int hv; int hf; int hsy; int hb;
    int vv; int vf; int vsy; int vb;
  } tim_t;

  localparam tim_t P_DEF = '{640, 16, 96, 48, 480, 10, 2, 33};
  localparam tim_t P_SML = '{8, 2, 3, 2, 6, 2, 2, 3};

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [9:0] dx_d, dy_d, dx_s, dy_s;
  logic       bl_d, hs_d, vs_d, fs_d;
  logic       bl_s, hs_s, vs_s, fs_s;

  int n_checks = 0;
  int n_errors = 0;
  int t = 0;          // cycles since the last reset edge; 0 = reset state
  int fs_seen = 0;
  int fs_first = -1;

  always #20 clk = ~clk;

  vga_timing_gen u_dut (
    .vga_clk(clk), .reset_n(reset_n), .DrawX(dx_d), .DrawY(dy_d),
    .blank(bl_d), .hs(hs_d), .vs(vs_d), .frame_start(fs_d)
  );

  vga_timing_gen #(
    .H_VISIBLE(P_SML.hv), .H_FRONT(P_SML.hf), .H_SYNC(P_SML.hsy), .H_BACK(P_SML.hb),
    .V_VISIBLE(P_SML.vv), .V_FRONT(P_SML.vf), .V_SYNC(P_SML.vsy), .V_BACK(P_SML.vb)
  ) u_dut_s (
    .vga_clk(clk), .reset_n(reset_n), .DrawX(dx_s), .DrawY(dy_s),
    .blank(bl_s), .hs(hs_s), .vs(vs_s), .frame_start(fs_s)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s t=%0d: got %0d expected %0d", tag, t, obs, exp);
    end
  endtask

  function automatic int h_tot(input tim_t p);
    return p.hv + p.hf + p.hsy + p.hb;
  endfunction

  function automatic int v_tot(input tim_t p);
    return p.vv + p.vf + p.vsy + p.vb;
  endfunction

  function automatic int px(input tim_t p, input int tt);
    return tt % h_tot(p);
  endfunction

  function automatic int py(input tim_t p, input int tt);
    return (tt / h_tot(p)) % v_tot(p);
  endfunction

  function automatic int hs_at(input tim_t p, input int tt);
    int x = px(p, tt);
    return (x >= p.hv + p.hf && x < p.hv + p.hf + p.hsy) ? 0 : 1;
  endfunction

  function automatic int vs_at(input tim_t p, input int tt);
    int y = py(p, tt);
    return (y >= p.vv + p.vf && y < p.vv + p.vf + p.vsy) ? 0 : 1;
  endfunction

  task automatic check_inst(input string who, input tim_t p, input logic [9:0] dx,
                            input logic [9:0] dy, input logic bl, input logic hs,
                            input logic vs, input logic fs);
    int x = px(p, t);
    int y = py(p, t);
    int ehs, evs;
`ifdef VGA_SYNC_DELAY_EN
    ehs = (t == 0) ? 1 : hs_at(p, t - 1);
    evs = (t == 0) ? 1 : vs_at(p, t - 1);
`else
    ehs = hs_at(p, t);
    evs = vs_at(p, t);
`endif
    check({who, ".x"}, int'(dx), x);
    check({who, ".y"}, int'(dy), y);
    check({who, ".blank"}, int'(bl), (x < p.hv && y < p.vv) ? 1 : 0);
    check({who, ".hs"}, int'(hs), ehs);
    check({who, ".vs"}, int'(vs), evs);
    check({who, ".fs"}, int'(fs), (t > 0 && x == 0 && y == 0) ? 1 : 0);
  endtask

  // One clock: advance the model according to the reset level seen at the edge, then compare.
  task automatic step();
    logic r = reset_n;
    @(posedge clk);
    #1;
    t = r ? t + 1 : 0;
    check_inst("def", P_DEF, dx_d, dy_d, bl_d, hs_d, vs_d, fs_d);
    check_inst("sml", P_SML, dx_s, dy_s, bl_s, hs_s, vs_s, fs_s);
    if (fs_s) begin
      fs_seen++;
      if (fs_first < 0) fs_first = t;
    end
  endtask

  initial begin
    int budget;
    int seg;
    reset_n = 1'b0;
    repeat (5) step();
    check("rst.x", int'(dx_d), 0);
    check("rst.hs", int'(hs_d), 1);
    check("rst.blank", int'(bl_d), 1);

    reset_n = 1'b1;
    step();
    check("rel.x", int'(dx_d), 1);
    check("rel.y", int'(dy_d), 0);

    // Two full default lines plus the start of a third.
    repeat (1700) step();
    check("line.y", int'(dy_d), 2);

    // Reset the small instance while both of its syncs are low, mid-line.
    budget = 2000;
    while (!(int'(dx_s) == P_SML.hv + P_SML.hf + 1 &&
             int'(dy_s) == P_SML.vv + P_SML.vf + 1) && budget > 0) begin
      step();
      budget--;
    end
    check("sync_wait.timeout", (budget > 0) ? 1 : 0, 1);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    check("midrst.x", int'(dx_s), 0);
    check("midrst.fs", int'(fs_s), 0);

    // Small-instance frame strobe: first pulse exactly one frame after release.
    fs_seen  = 0;
    fs_first = -1;
    repeat (3 * h_tot(P_SML) * v_tot(P_SML) + 5) step();
    check("fs.count", fs_seen, 3);
    check("fs.first", fs_first, h_tot(P_SML) * v_tot(P_SML));

    // Randomized reset pulses and run lengths.
    for (int i = 0; i < 8; i++) begin
      reset_n = 1'b0;
      seg = $urandom_range(1, 3);
      repeat (seg) step();
      reset_n = 1'b1;
      seg = $urandom_range(30, 600);
      repeat (seg) step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
